ac_zone_scheduler: RTL and testbench
====================================

// Module: ac_zone_scheduler
// PURPOSE
//  - Shares one AC compressor among NZ zones. Each zone supplies a request and a
//    temp_comp-style code; the block grants one zone at a time (damper select).
//  - Drives the compressor action code, enforcing a minimum run time and a
//    post-run lockout (anti-short-cycle).
//  - Sits between the per-zone thermostat comparators and the compressor/AC controller.
// PARAMETERS
//  NZ       4   number of zones (2..8)
//  CW       8   width of run/lockout counters
//  MIN_ON   8   minimum cycles in RUN before release is allowed (1..2^CW-1)
//  MIN_OFF  4   cycles spent in LOCKOUT after every RUN (1..2^CW-1)
//  QUANTUM  16  max RUN cycles while another zone waits (AC_PREEMPT_EN only; >= MIN_ON)
// PORTS
//  clk            in   1     system clock, rising edge
//  reset_n        in   1     asynchronous reset, active-low
//  power          in   1     1 = system enabled
//  zone_req       in   NZ    per-zone conditioning request
//  zone_comp      in   2*NZ  per-zone code, zone i at [2i+1:2i]: 10 = hotter (cool), 01 = colder (heat), 00/11 = none
//  grant          out  NZ    one-hot damper select, or all-zero
//  action         out  2     00 = off, 01 = heat (increase), 10 = cool (decrease)
//  state_display  out  2     00 = OFF, 01 = IDLE, 10 = RUN, 11 = LOCKOUT
// BEHAVIOUR
//  - All outputs registered. Reset: state OFF, grant = 0, action = 00,
//    state_display = 00, round-robin pointer = 0, counters = 0.
//  - Zone i is valid when zone_req[i] = 1 and its code is 01 or 10.
//  - OFF: power = 1 -> IDLE.
//  - IDLE: power = 0 -> OFF. Otherwise, if any zone is valid, pick the first valid
//    zone searching from ptr upward, modulo NZ. Next edge: RUN, grant = onehot(i),
//    action = code of zone i (latched), ptr = (i+1) % NZ.
//    Latency from request to grant/action is 1 clock.
//  - RUN: run counter starts at 1 on entry and saturates at 2^CW-1. action stays
//    latched for the whole RUN, even if the zone's code flips.
//    Release when run >= MIN_ON and the granted zone is no longer valid
//    (req low, or code 00/11).
//    Power = 0 in RUN releases immediately, ignoring MIN_ON (compressor protection
//    still applies via LOCKOUT).
//  - Release: next edge is LOCKOUT, with grant = 0, action = 00, lockout counter = 1.
//  - LOCKOUT: stays for exactly MIN_OFF cycles, ignoring all requests.
//    Then goes to IDLE if power = 1, else OFF.
//  - Simultaneous events: power = 0 has priority over every release or grant
//    decision. A request that appears in the same cycle LOCKOUT ends is served on
//    the IDLE cycle that follows; no direct LOCKOUT -> RUN.
//  - Async reset asserted mid-RUN forces the reset values immediately; no lockout
//    is applied after reset.
//  - grant is never multi-hot. action != 00 only in RUN.
// CONFIGURATION
//  AC_PREEMPT_EN defined:
//    - Extra RUN release condition: run >= QUANTUM and any other zone is valid.
//    - Released zone gets no special priority; ptr already points past it.
//  AC_PREEMPT_EN undefined:
//    - A zone holds the compressor until it goes invalid or power drops.
//    - QUANTUM is unused.
// TESTING (NZ=4, MIN_ON=8, MIN_OFF=4, QUANTUM=16)
//  1. reset_n = 0 then 1, power = 0, zone_req = 4'b1111 -> grant = 0, action = 00,
//     state_display = 00 indefinitely.
//  2. power = 1, zone_req = 4'b0100, zone 2 code 10 -> IDLE one cycle, then
//     grant = 0100, action = 10. Drop req at run = 3 -> RUN until run = 8,
//     then LOCKOUT exactly 4 cycles, then IDLE.
//  3. zone_req = 4'b1011, all codes 01 -> grant order 0001, 0010, 1000, 0001
//     across successive release cycles; round-robin wraps.
//  4. RUN on zone 1, power -> 0 at run = 2 -> next edge action = 00,
//     state_display = 11; after 4 cycles state_display = 00.
//  5. AC_PREEMPT_EN: zones 0 and 3 held valid -> zone 0 released at run = 16,
//     LOCKOUT 4 cycles, then grant = 1000. Without the macro, zone 0 is kept.
//  6. Zone 0 code 01 -> 10 during RUN -> action stays 01 until release;
//     reset_n pulse mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/ac_zone_scheduler_if.sv
// Zone-side and compressor-side signals of the AC zone scheduler.
// The scheduler attaches through the slave modport; stimulus sources use master.
interface ac_zone_scheduler_if #(
  parameter int NZ = 4
);
  logic              power;
  logic [NZ-1:0]     zone_req;
  logic [2*NZ-1:0]   zone_comp;
  logic [NZ-1:0]     grant;
  logic [1:0]        action;
  logic [1:0]        state_display;

  modport master (
    output power, zone_req, zone_comp,
    input  grant, action, state_display
  );

  modport slave (
    input  power, zone_req, zone_comp,
    output grant, action, state_display
  );
endinterface

// File: rtl/ac_zone_scheduler.sv
// Shares one AC compressor among NZ zones: round-robin grant, minimum run time,
// post-run lockout. Define AC_PREEMPT_EN to time-slice a zone after QUANTUM cycles.
module ac_zone_scheduler #(
  parameter int NZ      = 4,
  parameter int CW      = 8,
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 4,
  parameter int QUANTUM = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  ac_zone_scheduler_if.slave bus
);

  localparam int PW = (NZ > 1) ? $clog2(NZ) : 1;
  localparam logic [CW-1:0] MinOnC   = CW'(MIN_ON);
  localparam logic [CW-1:0] MinOffC  = CW'(MIN_OFF);
  localparam logic [CW-1:0] QuantumC = CW'(QUANTUM);

`ifdef AC_PREEMPT_EN
  localparam bit PreemptOn = 1'b1;
`else
  localparam bit PreemptOn = 1'b0;
`endif

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StIdle = 2'b01,
    StRun  = 2'b10,
    StLock = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [NZ-1:0]   grant_q, grant_d;
  logic [1:0]      action_q, action_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   runCnt_q, runCnt_d;
  logic [CW-1:0]   lockCnt_q, lockCnt_d;

  logic [NZ-1:0]   zoneValid;
  logic            anyValid;
  logic [PW-1:0]   selIdx;
  logic [1:0]      selCode;
  logic            holdValid;
  logic            otherValid;
  logic            runDone;

  // A zone wants service only with a request and exactly one of the two code bits set.
  always_comb begin
    zoneValid = '0;
    for (int i = 0; i < NZ; i++) begin
      zoneValid[i] = bus.zone_req[i] & (bus.zone_comp[2*i+1] ^ bus.zone_comp[2*i]);
    end
  end

  // Descending scan so the candidate closest to ptr_q is the one left standing.
  always_comb begin
    anyValid = 1'b0;
    selIdx   = '0;
    for (int k = NZ - 1; k >= 0; k--) begin
      if (zoneValid[(int'(ptr_q) + k) % NZ]) begin
        anyValid = 1'b1;
        selIdx   = PW'((int'(ptr_q) + k) % NZ);
      end
    end
  end

  assign selCode    = bus.zone_comp[2*int'(selIdx) +: 2];
  assign holdValid  = |(grant_q & zoneValid);
  assign otherValid = |(~grant_q & zoneValid);
  assign runDone    = ((runCnt_q >= MinOnC) && !holdValid) ||
                      (PreemptOn && (runCnt_q >= QuantumC) && otherValid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StOff;
      grant_q   <= '0;
      action_q  <= 2'b00;
      ptr_q     <= '0;
      runCnt_q  <= '0;
      lockCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      action_q  <= action_d;
      ptr_q     <= ptr_d;
      runCnt_q  <= runCnt_d;
      lockCnt_q <= lockCnt_d;
    end
  end

  // Power loss outranks every grant or release decision; lockout is never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff: begin
        if (bus.power) state_d = StIdle;
      end
      StIdle: begin
        if (!bus.power)    state_d = StOff;
        else if (anyValid) state_d = StRun;
      end
      StRun: begin
        if (!bus.power || runDone) state_d = StLock;
      end
      StLock: begin
        if (lockCnt_q >= MinOffC) state_d = bus.power ? StIdle : StOff;
      end
      default: state_d = StOff;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    action_d  = action_q;
    ptr_d     = ptr_q;
    runCnt_d  = runCnt_q;
    lockCnt_d = lockCnt_q;
    case (state_q)
      StOff: begin
        grant_d  = '0;
        action_d = 2'b00;
      end
      StIdle: begin
        if (state_d == StRun) begin
          grant_d  = NZ'(1) << selIdx;
          action_d = selCode;
          ptr_d    = PW'((int'(selIdx) + 1) % NZ);
          runCnt_d = CW'(1);
        end
      end
      StRun: begin
        if (state_d == StLock) begin
          grant_d   = '0;
          action_d  = 2'b00;
          lockCnt_d = CW'(1);
        end else if (runCnt_q != '1) begin
          runCnt_d = runCnt_q + CW'(1);
        end
      end
      StLock: begin
        if (state_d == StLock) lockCnt_d = lockCnt_q + CW'(1);
      end
      default: begin
        grant_d  = '0;
        action_d = 2'b00;
      end
    endcase
  end

  assign bus.grant         = grant_q;
  assign bus.action        = action_q;
  assign bus.state_display = state_q;

endmodule

// File: tb/tb_ac_zone_scheduler.sv
// Bench for ac_zone_scheduler: directed scenarios and random stimulus, every
// cycle compared against a countdown-style behavioural model of the scheduler.
module tb_ac_zone_scheduler;

  localparam int NZ      = 4;
  localparam int CW      = 8;
  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 4;
  localparam int QUANTUM = 16;
  localparam int SatMax  = (1 << CW) - 1;

`ifdef AC_PREEMPT_EN
  localparam bit Preempt = 1'b1;
`else
  localparam bit Preempt = 1'b0;
`endif

  localparam int MOff  = 0;
  localparam int MIdle = 1;
  localparam int MRun  = 2;
  localparam int MLock = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  ac_zone_scheduler_if #(.NZ(NZ)) bus ();

  ac_zone_scheduler #(
    .NZ(NZ), .CW(CW), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .QUANTUM(QUANTUM)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errCount   = 0;

  int mState, mGrant, mAction, mPtr, mRun, mLockLeft;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit zoneOk(input int i);
    logic [1:0] c;
    c = bus.zone_comp[2*i +: 2];
    return bus.zone_req[i] && (c == 2'b01 || c == 2'b10);
  endfunction

  task automatic modelReset();
    mState    = MOff;
    mGrant    = -1;
    mAction   = 0;
    mPtr      = 0;
    mRun      = 0;
    mLockLeft = 0;
  endtask

  // mLockLeft counts the lockout cycles still owed after the current one.
  task automatic modelStep();
    bit ok [NZ];
    bit others;
    int pick;
    for (int i = 0; i < NZ; i++) ok[i] = zoneOk(i);
    case (mState)
      MOff: begin
        if (bus.power) mState = MIdle;
      end
      MIdle: begin
        if (!bus.power) mState = MOff;
        else begin
          pick = -1;
          for (int k = 0; k < NZ; k++)
            if (pick < 0 && ok[(mPtr + k) % NZ]) pick = (mPtr + k) % NZ;
          if (pick >= 0) begin
            mState  = MRun;
            mGrant  = pick;
            mAction = int'(bus.zone_comp[2*pick +: 2]);
            mPtr    = (pick + 1) % NZ;
            mRun    = 1;
          end
        end
      end
      MRun: begin
        others = 1'b0;
        for (int i = 0; i < NZ; i++) if (i != mGrant && ok[i]) others = 1'b1;
        if (!bus.power || (mRun >= MIN_ON && !ok[mGrant]) ||
            (Preempt && mRun >= QUANTUM && others)) begin
          mState    = MLock;
          mGrant    = -1;
          mAction   = 0;
          mLockLeft = MIN_OFF - 1;
        end else if (mRun < SatMax) begin
          mRun++;
        end
      end
      MLock: begin
        if (mLockLeft == 0) mState = bus.power ? MIdle : MOff;
        else mLockLeft--;
      end
      default: ;
    endcase
  endtask

  task automatic checkCycle();
    logic [NZ-1:0] eg;
    eg = (mGrant < 0) ? '0 : NZ'(1 << mGrant);
    checkOutput("grant", bus.grant, eg);
    checkOutput("action", bus.action, mAction[1:0]);
    checkOutput("state", bus.state_display, mState[1:0]);
    checkOutput("grantOneHot0", $onehot0(bus.grant), 1);
    checkOutput("actionOnlyInRun", (bus.action != 2'b00) && (bus.state_display != 2'b10), 0);
  endtask

  task automatic applyStimulus(input bit pw, input logic [NZ-1:0] rq, input logic [2*NZ-1:0] cp);
    bus.power     = pw;
    bus.zone_req  = rq;
    bus.zone_comp = cp;
    @(posedge clk);
    modelStep();
    #1;
    checkCycle();
  endtask

  // Asserted between edges so the asynchronous clear is visible before any clock.
  task automatic doReset();
    reset_n = 1'b0;
    #1;
    modelReset();
    checkCycle();
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    int runSeen, lockSeen, firstRun, seenLock;
    logic [NZ-1:0] nextGrant;
    logic [NZ-1:0] order [4];
    logic [NZ-1:0] expOrder [4];
    logic [NZ-1:0] rq3, rq;
    logic [2*NZ-1:0] cp;
    bit pw;

    expOrder = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    bus.power     = 1'b0;
    bus.zone_req  = '0;
    bus.zone_comp = '0;
    #1;
    doReset();

    $display("[TB] scenario 1: power off holds OFF");
    repeat (6) applyStimulus(1'b0, 4'b1111, 8'b10101010);
    checkOutput("t1_stateOff", bus.state_display, 2'b00);

    $display("[TB] scenario 2: single zone, minimum run and lockout");
    applyStimulus(1'b1, 4'b0100, 8'b00100000);
    checkOutput("t2_idle", bus.state_display, 2'b01);
    applyStimulus(1'b1, 4'b0100, 8'b00100000);
    checkOutput("t2_grant", bus.grant, 4'b0100);
    checkOutput("t2_action", bus.action, 2'b10);
    runSeen  = (bus.state_display == 2'b10) ? 1 : 0;
    lockSeen = 0;
    repeat (2) begin
      applyStimulus(1'b1, 4'b0100, 8'b00100000);
      if (bus.state_display == 2'b10) runSeen++;
    end
    repeat (20) begin
      applyStimulus(1'b1, 4'b0000, 8'b00100000);
      if (bus.state_display == 2'b10) runSeen++;
      if (bus.state_display == 2'b11) lockSeen++;
    end
    checkOutput("t2_runCycles", runSeen, MIN_ON);
    checkOutput("t2_lockCycles", lockSeen, MIN_OFF);
    checkOutput("t2_idleAfter", bus.state_display, 2'b01);

    $display("[TB] scenario 3: round-robin order with wrap");
    doReset();
    rq3 = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 30 && bus.state_display != 2'b10; n++)
        applyStimulus(1'b1, rq3, 8'b01010101);
      checkOutput("t3_inRun", bus.state_display, 2'b10);
      order[g] = bus.grant;
      for (int n = 0; n < 30 && bus.state_display == 2'b10; n++)
        applyStimulus(1'b1, rq3 & ~order[g], 8'b01010101);
      checkOutput("t3_released", bus.state_display, 2'b11);
      checkOutput("t3_order", order[g], expOrder[g]);
    end

    $display("[TB] scenario 4: power loss during run");
    doReset();
    for (int n = 0; n < 10 && bus.state_display != 2'b10; n++)
      applyStimulus(1'b1, 4'b0010, 8'b00000100);
    checkOutput("t4_grant", bus.grant, 4'b0010);
    applyStimulus(1'b1, 4'b0010, 8'b00000100);
    applyStimulus(1'b0, 4'b0010, 8'b00000100);
    checkOutput("t4_lockState", bus.state_display, 2'b11);
    checkOutput("t4_actionOff", bus.action, 2'b00);
    lockSeen = 1;
    repeat (5) begin
      applyStimulus(1'b0, 4'b0010, 8'b00000100);
      if (bus.state_display == 2'b11) lockSeen++;
    end
    checkOutput("t4_lockCycles", lockSeen, MIN_OFF);
    checkOutput("t4_offAfter", bus.state_display, 2'b00);

    $display("[TB] scenario 5: two zones held valid");
    doReset();
    firstRun  = 0;
    seenLock  = 0;
    nextGrant = '0;
    repeat (40) begin
      applyStimulus(1'b1, 4'b1001, 8'b01000001);
      if (bus.state_display == 2'b11) seenLock = 1;
      else if (bus.state_display == 2'b10) begin
        if (seenLock == 0) firstRun++;
        else if (nextGrant == '0) nextGrant = bus.grant;
      end
    end
`ifdef AC_PREEMPT_EN
    checkOutput("t5_quantumRun", firstRun, QUANTUM);
    checkOutput("t5_nextGrant", nextGrant, 4'b1000);
`else
    checkOutput("t5_heldRun", firstRun, 39);
    checkOutput("t5_noLock", seenLock, 0);
`endif

    $display("[TB] scenario 6: latched action and reset mid-run");
    doReset();
    for (int n = 0; n < 10 && bus.state_display != 2'b10; n++)
      applyStimulus(1'b1, 4'b0001, 8'b00000001);
    repeat (3) applyStimulus(1'b1, 4'b0001, 8'b00000001);
    repeat (12) begin
      applyStimulus(1'b1, 4'b0001, 8'b00000010);
      checkOutput("t6_actionLatched", bus.action, 2'b01);
    end
    doReset();
    checkOutput("t6_rstGrant", bus.grant, 4'b0000);
    checkOutput("t6_rstAction", bus.action, 2'b00);
    checkOutput("t6_rstState", bus.state_display, 2'b00);
    repeat (4) applyStimulus(1'b1, 4'b0001, 8'b00000010);

    $display("[TB] random phase");
    pw = 1'b1;
    rq = '0;
    cp = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        rq = NZ'($urandom);
        cp = (2*NZ)'($urandom);
      end
      if ($urandom_range(0, 19) == 0) pw = ~pw;
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus(pw, rq, cp);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
